// File: rtl/isla_idelay_calib.sv
// IDELAY tap manager for N-lane LVDS ADC inputs.
// Host can load taps directly, or run a per-lane sweep that finds the widest
// passing window against the ADC test pattern and parks the lane at its centre.
module isla_idelay_calib #(
    parameter int g_num_lanes     = 8,
    parameter int g_tap_width     = 5,
    parameter int g_settle_cycles = 16,
    parameter int g_check_cycles  = 64,
    parameter int g_min_window    = 3,
    parameter int g_default_tap   = 0
) (
    input  logic                               sys_clk,
    input  logic                               rst_n,
    input  logic                               idelay_rdy_i,
    input  logic                               cal_start_i,
    input  logic [g_tap_width-1:0]             man_tap_i,
    input  logic [g_num_lanes-1:0]             man_sel_i,
    input  logic                               man_load_i,
    input  logic [2*g_num_lanes-1:0]           lane_data_i,
    input  logic [2*g_num_lanes-1:0]           pattern_i,
    output logic [g_tap_width-1:0]             idly_cntvalue_o,
    output logic [g_num_lanes-1:0]             idly_ld_o,
    output logic [g_num_lanes*g_tap_width-1:0] lane_tap_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [g_num_lanes-1:0]             fail_o
);

    localparam int LANE_W  = (g_num_lanes > 1) ? $clog2(g_num_lanes) : 1;
    localparam int CNT_MAX = (g_settle_cycles > g_check_cycles) ? g_settle_cycles : g_check_cycles;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [g_tap_width-1:0] TAP_MAX     = {g_tap_width{1'b1}};
    localparam logic [g_tap_width-1:0] TAP_ZERO    = {g_tap_width{1'b0}};
    localparam logic [g_tap_width-1:0] TAP_ONE     = g_tap_width'(1);
    localparam logic [g_tap_width-1:0] DEF_TAP     = g_tap_width'(g_default_tap);
    localparam logic [g_tap_width:0]   LEN_ZERO    = {(g_tap_width+1){1'b0}};
    localparam logic [g_tap_width:0]   LEN_ONE     = (g_tap_width+1)'(1);
    localparam logic [g_tap_width:0]   MIN_WIN     = (g_tap_width+1)'(g_min_window);
    localparam logic [LANE_W-1:0]      LANE_ZERO   = {LANE_W{1'b0}};
    localparam logic [LANE_W-1:0]      LANE_ONE    = LANE_W'(1);
    localparam logic [LANE_W-1:0]      LAST_LANE   = LANE_W'(g_num_lanes - 1);
    localparam logic [CNT_W-1:0]       CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]       CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]       SETTLE_LAST = CNT_W'(g_settle_cycles - 1);
    localparam logic [CNT_W-1:0]       CHECK_LAST  = CNT_W'(g_check_cycles - 1);
    localparam logic [g_num_lanes-1:0] LANES_ZERO  = {g_num_lanes{1'b0}};
    localparam logic [g_num_lanes-1:0] LANES_ONE   = g_num_lanes'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_CHECK     = 3'd3,
        ST_NEXT      = 3'd4,
        ST_CENTER    = 3'd5,
        ST_CENTER_LD = 3'd6,
        ST_FIN       = 3'd7
    } state_t;

    state_t                              r_state, w_state;
    logic [LANE_W-1:0]                   r_lane, w_lane;
    logic [g_tap_width-1:0]              r_tap, w_tap;
    logic [CNT_W-1:0]                    r_cnt, w_cnt;
    logic                                r_pass, w_pass;
    logic [g_tap_width-1:0]              r_run_start, w_run_start;
    logic [g_tap_width:0]                r_run_len, w_run_len;
    logic [g_tap_width-1:0]              r_best_start, w_best_start;
    logic [g_tap_width:0]                r_best_len, w_best_len;
    logic                                r_man_d;
    logic [g_tap_width-1:0]              r_cntvalue, w_cntvalue;
    logic [g_num_lanes-1:0]              r_ld, w_ld;
    logic [g_num_lanes-1:0][g_tap_width-1:0] r_lane_tap, w_lane_tap;
    logic                                r_busy, w_busy;
    logic                                r_done, w_done;
    logic [g_num_lanes-1:0]              r_fail, w_fail;

    logic                                w_man_edge;
    logic                                w_match;
    logic                                w_abort;
    logic [LANE_W-1:0]                   w_lane_inc;
    logic [g_num_lanes-1:0]              w_lane_bit;
    logic [g_num_lanes-1:0]              w_next_bit;
    logic [g_num_lanes-1:0]              w_rem_mask;
    logic [g_tap_width-1:0]              w_fin_start;
    logic [g_tap_width:0]                w_fin_len;
    logic [g_tap_width:0]                w_half;
    logic [g_tap_width-1:0]              w_center_tap;
    logic                                w_center_ok;

    assign w_man_edge = man_load_i & ~r_man_d;
    assign w_match    = (lane_data_i[{r_lane, 1'b0} +: 2] == pattern_i[{r_lane, 1'b0} +: 2]);
    assign w_abort    = ~idelay_rdy_i && (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign w_lane_inc = r_lane + LANE_ONE;
    assign w_lane_bit = LANES_ONE << r_lane;
    assign w_next_bit = LANES_ONE << w_lane_inc;
    // Current lane and every lane after it.
    assign w_rem_mask = ~(w_lane_bit - LANES_ONE);

    // A run still open at the top tap is closed here; no wrap to tap 0.
    assign w_fin_len    = (r_run_len > r_best_len) ? r_run_len   : r_best_len;
    assign w_fin_start  = (r_run_len > r_best_len) ? r_run_start : r_best_start;
    assign w_half       = (w_fin_len - LEN_ONE) >> 1;
    assign w_center_tap = w_fin_start + w_half[g_tap_width-1:0];
    assign w_center_ok  = (w_fin_len >= MIN_WIN);

    // Next-state, window tracking and next output values.
    always_comb begin
        w_state      = r_state;
        w_lane       = r_lane;
        w_tap        = r_tap;
        w_cnt        = r_cnt;
        w_pass       = r_pass;
        w_run_start  = r_run_start;
        w_run_len    = r_run_len;
        w_best_start = r_best_start;
        w_best_len   = r_best_len;
        w_cntvalue   = r_cntvalue;
        w_ld         = LANES_ZERO;
        w_lane_tap   = r_lane_tap;
        w_done       = 1'b0;
        w_fail       = r_fail;

        if (w_abort) begin
            // IDELAYCTRL lost ready: current and untouched lanes are failed,
            // their programmed taps are left alone.
            w_state = ST_IDLE;
            w_done  = 1'b1;
            w_fail  = r_fail | w_rem_mask;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cal_start_i && idelay_rdy_i) begin
                        w_state      = ST_LOAD;
                        w_lane       = LANE_ZERO;
                        w_tap        = TAP_ZERO;
                        w_cnt        = CNT_ZERO;
                        w_run_start  = TAP_ZERO;
                        w_run_len    = LEN_ZERO;
                        w_best_start = TAP_ZERO;
                        w_best_len   = LEN_ZERO;
                        w_fail       = LANES_ZERO;
                        w_ld         = LANES_ONE;
                        w_cntvalue   = TAP_ZERO;
                    end else if (w_man_edge) begin
                        w_ld       = man_sel_i;
                        w_cntvalue = man_tap_i;
                        for (int i = 0; i < g_num_lanes; i++) begin
                            if (man_sel_i[i]) begin
                                w_lane_tap[i] = man_tap_i;
                            end else begin
                                w_lane_tap[i] = r_lane_tap[i];
                            end
                        end
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    w_state = ST_SETTLE;
                    w_cnt   = CNT_ZERO;
                end
                ST_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_state = ST_CHECK;
                        w_cnt   = CNT_ZERO;
                    end else begin
                        w_cnt = r_cnt + CNT_ONE;
                    end
                end
                ST_CHECK: begin
                    if (!w_match) begin
                        w_pass  = 1'b0;
                        w_state = ST_NEXT;
                    end else if (r_cnt == CHECK_LAST) begin
                        w_pass  = 1'b1;
                        w_state = ST_NEXT;
                    end else begin
                        w_cnt = r_cnt + CNT_ONE;
                    end
                end
                ST_NEXT: begin
                    if (r_pass) begin
                        if (r_run_len == LEN_ZERO) begin
                            w_run_start = r_tap;
                        end else begin
                            w_run_start = r_run_start;
                        end
                        w_run_len = r_run_len + LEN_ONE;
                    end else begin
                        // Strictly longer replaces best, so the earliest window wins ties.
                        if (r_run_len > r_best_len) begin
                            w_best_start = r_run_start;
                            w_best_len   = r_run_len;
                        end else begin
                            w_best_len = r_best_len;
                        end
                        w_run_len = LEN_ZERO;
                    end
                    if (r_tap != TAP_MAX) begin
                        w_tap      = r_tap + TAP_ONE;
                        w_state    = ST_LOAD;
                        w_ld       = w_lane_bit;
                        w_cntvalue = r_tap + TAP_ONE;
                    end else begin
                        w_state = ST_CENTER;
                    end
                end
                ST_CENTER: begin
                    w_state = ST_CENTER_LD;
                    w_ld    = w_lane_bit;
                    if (w_center_ok) begin
                        w_tap              = w_center_tap;
                        w_cntvalue         = w_center_tap;
                        w_lane_tap[r_lane] = w_center_tap;
                    end else begin
                        w_tap              = DEF_TAP;
                        w_cntvalue         = DEF_TAP;
                        w_lane_tap[r_lane] = DEF_TAP;
                        w_fail             = r_fail | w_lane_bit;
                    end
                end
                ST_CENTER_LD: begin
                    if (r_lane == LAST_LANE) begin
                        w_state = ST_FIN;
                        w_done  = 1'b1;
                    end else begin
                        w_state      = ST_LOAD;
                        w_lane       = w_lane_inc;
                        w_tap        = TAP_ZERO;
                        w_cnt        = CNT_ZERO;
                        w_run_start  = TAP_ZERO;
                        w_run_len    = LEN_ZERO;
                        w_best_start = TAP_ZERO;
                        w_best_len   = LEN_ZERO;
                        w_ld         = w_next_bit;
                        w_cntvalue   = TAP_ZERO;
                    end
                end
                ST_FIN: begin
                    w_state = ST_IDLE;
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end

        w_busy = (w_state != ST_IDLE) && (w_state != ST_FIN);
    end

    // State, sweep bookkeeping and registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_lane       <= LANE_ZERO;
            r_tap        <= TAP_ZERO;
            r_cnt        <= CNT_ZERO;
            r_pass       <= 1'b0;
            r_run_start  <= TAP_ZERO;
            r_run_len    <= LEN_ZERO;
            r_best_start <= TAP_ZERO;
            r_best_len   <= LEN_ZERO;
            r_man_d      <= 1'b0;
            r_cntvalue   <= TAP_ZERO;
            r_ld         <= LANES_ZERO;
            r_lane_tap   <= {(g_num_lanes*g_tap_width){1'b0}};
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= LANES_ZERO;
        end else begin
            r_state      <= w_state;
            r_lane       <= w_lane;
            r_tap        <= w_tap;
            r_cnt        <= w_cnt;
            r_pass       <= w_pass;
            r_run_start  <= w_run_start;
            r_run_len    <= w_run_len;
            r_best_start <= w_best_start;
            r_best_len   <= w_best_len;
            r_man_d      <= man_load_i;
            r_cntvalue   <= w_cntvalue;
            r_ld         <= w_ld;
            r_lane_tap   <= w_lane_tap;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_fail       <= w_fail;
        end
    end

    assign idly_cntvalue_o = r_cntvalue;
    assign idly_ld_o       = r_ld;
    assign lane_tap_o      = r_lane_tap;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign fail_o          = r_fail;

endmodule

// File: tb/tb_isla_idelay_calib.sv
// Bench for isla_idelay_calib: an IDELAY/ADC lane model feeds the pattern,
// a cycle timeline derived from the sweep rules is checked every cycle.
module tb_isla_idelay_calib;

    localparam int NL = 8;
    localparam int TW = 5;
    localparam int SC = 2;
    localparam int CC = 4;
    localparam int MW = 3;
    localparam int DT = 0;
    localparam int NT = 1 << TW;

    logic              sys_clk;
    logic              rst_n;
    logic              idelay_rdy_i;
    logic              cal_start_i;
    logic [TW-1:0]     man_tap_i;
    logic [NL-1:0]     man_sel_i;
    logic              man_load_i;
    logic [2*NL-1:0]   lane_data_i;
    logic [2*NL-1:0]   pattern_i;
    logic [TW-1:0]     idly_cntvalue_o;
    logic [NL-1:0]     idly_ld_o;
    logic [NL*TW-1:0]  lane_tap_o;
    logic              busy_o;
    logic              done_o;
    logic [NL-1:0]     fail_o;

    isla_idelay_calib #(
        .g_num_lanes(NL), .g_tap_width(TW), .g_settle_cycles(SC),
        .g_check_cycles(CC), .g_min_window(MW), .g_default_tap(DT)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .idelay_rdy_i(idelay_rdy_i),
        .cal_start_i(cal_start_i), .man_tap_i(man_tap_i), .man_sel_i(man_sel_i),
        .man_load_i(man_load_i), .lane_data_i(lane_data_i), .pattern_i(pattern_i),
        .idly_cntvalue_o(idly_cntvalue_o), .idly_ld_o(idly_ld_o),
        .lane_tap_o(lane_tap_o), .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o)
    );

    typedef struct packed {
        logic [NL-1:0]    ld;
        logic [TW-1:0]    cnt;
        logic             busy;
        logic             done;
        logic             chk_fail;
        logic [NL-1:0]    fail;
        logic [NL*TW-1:0] tap;
        int               lane;
    } rec_t;

    rec_t             q[$];
    logic [NL*TW-1:0] m_tap;
    logic [NL-1:0]    m_fail;
    logic             res_fail [NL];
    logic [NT-1:0]    pm [NL];
    int               bench_tap [NL];
    int               n_pass;
    int               n_tot;
    bit               chk_en;

    localparam logic [NL*TW-1:0] EXP1 = {5'd7, 5'd28, 5'd0, 5'd3, 5'd22, 5'd7, 5'd7, 5'd14};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic rec_t mk(input logic [NL-1:0] ld, input int cnt, input logic busy,
                                input logic done, input logic chkf, input logic [NL-1:0] fl,
                                input logic [NL*TW-1:0] tp, input int lane);
        rec_t r;
        r.ld = ld; r.cnt = TW'(cnt); r.busy = busy; r.done = done;
        r.chk_fail = chkf; r.fail = fl; r.tap = tp; r.lane = lane;
        return r;
    endfunction

    function automatic void push_idle();
        q.push_back(mk('0, 0, 1'b0, 1'b0, 1'b1, m_fail, m_tap, 0));
    endfunction

    function automatic logic [NT-1:0] win(input int lo, input int hi);
        logic [NT-1:0] m;
        m = '0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    function automatic logic [NT-1:0] rand_mask();
        logic [NT-1:0] m;
        int k, lo, len;
        m = '0;
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) begin
            lo  = $urandom_range(0, NT - 1);
            len = $urandom_range(1, 12);
            for (int t = lo; t < lo + len && t < NT; t++) m[t] = 1'b1;
        end
        return m;
    endfunction

    // Longest run of passing taps, earliest one on ties.
    function automatic void best_window(input logic [NT-1:0] m, output int bs, output int bl);
        int len;
        bs = 0; bl = 0;
        for (int s = 0; s < NT; s++) begin
            if (m[s] && ((s == 0) ? 1'b1 : !m[s-1])) begin
                len = 0;
                while (s + len < NT && m[s+len]) len++;
                if (len > bl) begin bl = len; bs = s; end
            end
        end
    endfunction

    // Expected per-cycle timeline of a full calibration accepted at the next edge.
    function automatic void cal_expect();
        logic [NL*TW-1:0] snap;
        logic [NL-1:0]    fl;
        int bs, bl, ct, nwait;
        bit ok;
        snap = m_tap;
        fl   = '0;
        push_idle();
        for (int l = 0; l < NL; l++) begin
            best_window(pm[l], bs, bl);
            ok = (bl >= MW);
            ct = ok ? bs + (bl - 1) / 2 : DT;
            res_fail[l] = !ok;
            for (int t = 0; t < NT; t++) begin
                q.push_back(mk(NL'(1) << l, t, 1'b1, 1'b0, 1'b0, '0, snap, l));
                nwait = SC + (pm[l][t] ? CC : 1) + 1;
                for (int k = 0; k < nwait; k++) q.push_back(mk('0, 0, 1'b1, 1'b0, 1'b0, '0, snap, l));
            end
            q.push_back(mk('0, 0, 1'b1, 1'b0, 1'b0, '0, snap, l));
            snap[l*TW +: TW] = TW'(ct);
            if (!ok) fl[l] = 1'b1;
            q.push_back(mk(NL'(1) << l, ct, 1'b1, 1'b0, 1'b0, '0, snap, l));
        end
        q.push_back(mk('0, 0, 1'b0, 1'b1, 1'b1, fl, snap, NL - 1));
        m_tap  = snap;
        m_fail = fl;
    endfunction

    // Ready drops during the cycle at the queue front: abort on the following edge.
    function automatic void abort_expect();
        rec_t r0;
        logic [NL-1:0] fl;
        r0 = q[0];
        for (int i = 0; i < NL; i++) fl[i] = (i < r0.lane) ? res_fail[i] : 1'b1;
        q.delete();
        q.push_back(r0);
        q.push_back(mk('0, 0, 1'b0, 1'b1, 1'b1, fl, r0.tap, r0.lane));
        m_fail = fl;
        m_tap  = r0.tap;
    endfunction

    // Lane model: IDELAY tap follows LD, data matches the pattern inside the pass mask.
    always @(negedge sys_clk) begin
        logic [1:0] p;
        for (int i = 0; i < NL; i++) begin
            if (!rst_n) bench_tap[i] = 0;
            else if (idly_ld_o[i]) bench_tap[i] = int'(idly_cntvalue_o);
            p = 2'($urandom_range(0, 3));
            pattern_i[2*i +: 2]   = p;
            lane_data_i[2*i +: 2] = pm[i][bench_tap[i]] ? p : ~p;
        end
    end

    // Per-cycle comparison against the expected timeline (idle when empty).
    always @(negedge sys_clk) begin
        rec_t e;
        if (chk_en && rst_n) begin
            if (q.size() > 0) e = q.pop_front();
            else e = mk('0, 0, 1'b0, 1'b0, 1'b1, m_fail, m_tap, 0);
            chk("ld", 64'(idly_ld_o), 64'(e.ld));
            if (e.ld != '0) chk("cntvalue", 64'(idly_cntvalue_o), 64'(e.cnt));
            chk("busy", 64'(busy_o), 64'(e.busy));
            chk("done", 64'(done_o), 64'(e.done));
            chk("lane_tap", 64'(lane_tap_o), 64'(e.tap));
            if (e.chk_fail) chk("fail", 64'(fail_o), 64'(e.fail));
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_cal();
        cal_start_i = 1'b1;
        cal_expect();
        tick();
        cal_start_i = 1'b0;
    endtask

    task automatic drain(input bit noise);
        for (int i = 0; i < 3000 && q.size() > 0; i++) begin
            if (noise && q.size() > 2 && q[0].busy) begin
                man_load_i  = 1'($urandom_range(0, 1));
                man_tap_i   = TW'($urandom);
                man_sel_i   = NL'($urandom);
                cal_start_i = 1'($urandom_range(0, 1));
            end else begin
                cal_start_i = 1'b0;
            end
            tick();
        end
        cal_start_i = 1'b0;
        man_load_i  = 1'b0;
        chk("timeline_drained", 64'(q.size()), 64'd0);
        tick();
    endtask

    task automatic man_load(input logic [TW-1:0] tp, input logic [NL-1:0] sel);
        man_tap_i  = tp;
        man_sel_i  = sel;
        man_load_i = 1'b1;
        push_idle();
        for (int i = 0; i < NL; i++) if (sel[i]) m_tap[i*TW +: TW] = tp;
        q.push_back(mk(sel, int'(tp), 1'b0, 1'b0, 1'b1, m_fail, m_tap, 0));
        tick();
        tick();
        man_load_i = 1'b0;
        tick();
    endtask

    task automatic check_reset_zero();
        chk("rst_cntvalue", 64'(idly_cntvalue_o), 64'd0);
        chk("rst_ld", 64'(idly_ld_o), 64'd0);
        chk("rst_lane_tap", 64'(lane_tap_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_fail", 64'(fail_o), 64'd0);
    endtask

    task automatic set_cal1();
        pm[0] = win(8, 20);
        pm[1] = win(4, 10);
        pm[2] = win(4, 10);
        pm[3] = win(2, 5) | win(18, 27);
        pm[4] = win(2, 5) | win(10, 13);
        pm[5] = '0;
        pm[6] = win(25, 31);
        pm[7] = win(4, 10);
    endtask

    initial begin
        n_pass = 0; n_tot = 0; chk_en = 1'b0;
        rst_n = 1'b0; idelay_rdy_i = 1'b1; cal_start_i = 1'b0;
        man_tap_i = '0; man_sel_i = '0; man_load_i = 1'b0;
        lane_data_i = '0; pattern_i = '0;
        m_tap = '0; m_fail = '0;
        for (int i = 0; i < NL; i++) begin pm[i] = '0; res_fail[i] = 1'b0; bench_tap[i] = 0; end

        repeat (3) tick();
        check_reset_zero();
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) tick();

        // Manual loads; level held high must not reload.
        man_load(5'd13, 8'h05);
        chk("man_lane0", 64'(lane_tap_o[4:0]), 64'd13);
        chk("man_lane2", 64'(lane_tap_o[14:10]), 64'd13);
        man_load(5'd31, 8'h82);

        // Start ignored without IDELAYCTRL ready.
        idelay_rdy_i = 1'b0;
        tick();
        cal_start_i = 1'b1;
        tick();
        cal_start_i = 1'b0;
        repeat (4) tick();
        idelay_rdy_i = 1'b1;
        tick();

        // Directed windows, with manual/start noise while busy.
        set_cal1();
        start_cal();
        chk("model_pin_taps", 64'(m_tap), 64'(EXP1));
        chk("model_pin_fail", 64'(m_fail), 64'h20);
        drain(1'b1);
        chk("cal1_taps", 64'(lane_tap_o), 64'(EXP1));
        chk("cal1_fail", 64'(fail_o), 64'h20);

        // Start coincident with a manual edge: calibration wins.
        for (int i = 0; i < NL; i++) pm[i] = rand_mask();
        man_tap_i = 5'd9; man_sel_i = 8'hFF; man_load_i = 1'b1;
        start_cal();
        drain(1'b0);

        // Randomised windows.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NL; i++) pm[i] = rand_mask();
            start_cal();
            drain(1'b1);
            if (r == 0) man_load(TW'($urandom), NL'($urandom));
        end

        // Ready lost during lane 2.
        for (int i = 0; i < NL; i++) pm[i] = win(4, 10);
        pm[0] = win(8, 20);
        start_cal();
        for (int i = 0; i < 3000 && !(q.size() > 0 && q[0].lane == 2 && q[0].busy); i++) tick();
        chk("reach_lane2", 64'(q.size() > 0 && q[0].lane == 2), 64'd1);
        repeat (10) tick();
        idelay_rdy_i = 1'b0;
        abort_expect();
        drain(1'b0);
        chk("abort_fail", 64'(fail_o), 64'hFC);
        chk("abort_taps01", 64'(lane_tap_o[9:0]), 64'({5'd7, 5'd14}));
        idelay_rdy_i = 1'b1;
        tick();

        // Asynchronous reset in the middle of a sweep, then a clean sweep.
        set_cal1();
        start_cal();
        repeat (300) tick();
        #1;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_zero();
        q.delete();
        m_tap = '0; m_fail = '0;
        repeat (3) tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (2) tick();
        start_cal();
        drain(1'b0);
        chk("post_rst_taps", 64'(lane_tap_o), 64'(EXP1));
        chk("post_rst_fail", 64'(fail_o), 64'h20);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/isla_idelay_calib.md
Name: isla_idelay_calib

Overview:
- Parametrised IDELAY tap manager for N-lane LVDS ADC data interfaces.
- Supports manual host tap loads plus an automatic per-lane training sweep against a known ADC test pattern.
- Drives shared CNTVALUEIN/per-lane LD of IDELAYE2-class primitives; sits between host registers and the ADC interface, in the sys_clk domain.
- Sample inputs arrive already resynchronised to sys_clk.

Parameters:
- g_num_lanes, 8, number of data lanes (1..16)
- g_tap_width, 5, IDELAY tap counter width (5 for 7-series, 9 for larger delay lines)
- g_settle_cycles, 16, sys_clk cycles waited after each tap load before checking
- g_check_cycles, 64, consecutive matching samples required for a tap to pass
- g_min_window, 3, minimum passing-window length (taps) for lane success
- g_default_tap, 0, tap loaded into a lane whose calibration fails

Ports:
- sys_clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- idelay_rdy_i  in  1  IDELAYCTRL ready
- cal_start_i  in  1  one-cycle pulse; start automatic calibration of all lanes
- man_tap_i  in  g_tap_width  manual tap value
- man_sel_i  in  g_num_lanes  manual lane select mask
- man_load_i  in  1  manual load request (level; rising edge acts)
- lane_data_i  in  2*g_num_lanes  IDDR bit pair per lane; lane i = bits [2i+1:2i]
- pattern_i  in  2*g_num_lanes  expected bit pair per lane
- idly_cntvalue_o  out  g_tap_width  shared CNTVALUEIN bus
- idly_ld_o  out  g_num_lanes  per-lane LD strobe
- lane_tap_o  out  g_num_lanes*g_tap_width  currently programmed tap per lane
- busy_o  out  1  calibration in progress
- done_o  out  1  one-cycle pulse at calibration end/abort
- fail_o  out  g_num_lanes  per-lane calibration failure flag (sticky until next cal start)

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; lane_tap_o all 0, matching IDELAY_VALUE 0.
  - FSM to IDLE; edge-detect register 0.
- Manual path, IDLE only:
  - man_load_i sampled 1 at edge k with 0 at edge k-1 → during cycle k+1, idly_cntvalue_o=man_tap_i (captured at k) and idly_ld_o=man_sel_i for exactly one cycle.
  - lane_tap_o updates for the selected lanes in the same cycle.
  - Edges while busy are dropped, not queued.
- cal_start_i is accepted only in IDLE with idelay_rdy_i=1; otherwise ignored.
- Simultaneous cal_start_i and manual edge in IDLE: calibration wins; the manual request is discarded.
- FSM: IDLE → LOAD → SETTLE → CHECK → NEXT → (LOAD | CENTER) → CENTER_LD → (LOAD of next lane | FIN) → IDLE.
  - LOAD: idly_cntvalue_o=tap, idly_ld_o one-hot lane, one cycle. Tap starts at 0 for each lane.
  - SETTLE: count g_settle_cycles.
  - CHECK: compare lane_data_i pair to pattern_i pair for g_check_cycles cycles. Any mismatch → tap fails; exit early to NEXT.
  - NEXT: update window tracking, then:
    - tap < 2^g_tap_width-1 → tap+1, LOAD.
    - else → CENTER.
  - Window tracking:
    - run_start, run_len, best_start, best_len.
    - Pass extends the current run.
    - Fail ends the run; best is replaced only if run_len > best_len strictly (earliest wins ties).
    - A run reaching the last tap is closed at CENTER, with no wrap-around to tap 0.
  - CENTER: if best_len >= g_min_window, tap = best_start + ((best_len-1)>>1), floor; else tap=g_default_tap and fail_o[lane]=1.
  - CENTER_LD: one LD cycle with that tap; update lane_tap_o. Next lane, or FIN after the last lane.
  - FIN: done_o=1 one cycle, busy_o=0.
- busy_o=1 from the cycle after cal_start_i acceptance through the FSM's last cycle before FIN.
- fail_o cleared on cal acceptance.
- Per-tap cost: 1 + g_settle_cycles + (≤ g_check_cycles) + 1 cycles.
- idelay_rdy_i falling during calibration:
  - Abort to IDLE next cycle; done_o pulses.
  - fail_o set for the current and all remaining lanes.
  - lane_tap_o unchanged for those lanes; no LD issued.
- Arithmetic: tap counter and window fields are g_tap_width bits; run_len/best_len are g_tap_width+1 bits so a full 2^W-long window is representable.

Test Plan:
- Manual: man_tap_i=13, man_sel_i=8'h05, rising man_load_i → one-cycle idly_ld_o=8'h05 with cntvalue 13; lane_tap lanes 0,2 = 13; edge during busy → no LD.
- Cal, lane 0 passes taps 8..20, others 4..10 → lane 0 tap 14, others tap 7; fail_o=0; single done_o pulse.
- Two windows on lane 3: 2..5 and 18..27 → tap 22; equal windows 2..5 and 10..13 → tap 3.
- Window reaching the top (25..31) → tap 28. Pattern never matches on lane 5 → fail_o[5]=1, tap g_default_tap=0.
- idelay_rdy_i low during lane 2 sweep → done_o pulse, fail_o=8'hFC, lanes 0-1 keep calibrated taps.
- rst_n asserted mid-sweep → all outputs 0 immediately (asynchronous); cal_start_i after release runs a full sweep normally.
